p7_datapath_param: RTL and testbench

Parametrised successor to the P6 datapath, built for the next CPU lab:
- configurable data width and register count;
- 8-operation ALU;
- multi-cycle iterative shifter with a start/busy/done handshake, replacing the fixed 1-bit combinational shifter.

It sits between the controller FSM and memory. The controller drives all load/select strobes and waits on shift_done.

---
 rtl/p7_datapath_param_pkg.sv | 20 ++
 rtl/p7_datapath_param_if.sv | 30 +++
 rtl/p7_regfile_param.sv | 25 ++
 rtl/p7_datapath_param.sv | 96 +++++++++
 tb/tb_p7_datapath_param.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/p7_datapath_param_pkg.sv
// p7_defs: shared ALU, write-select and shift codes for the P7 datapath
package p7_defs;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOTB = 3'b011;
  localparam logic [2:0] OP_OR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;
  localparam logic [1:0] VSEL_IN = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;
  localparam logic [1:0] VSEL_PC = 2'b11;
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL = 2'b01;
  localparam logic [1:0] SH_LSR = 2'b10;
  localparam logic [1:0] SH_ASR = 2'b11;
  typedef enum logic {SH_IDLE, SH_RUN} sh_state_t;
endpackage

// File: rtl/p7_datapath_param_if.sv
// p7_datapath_param_if: controller-facing strobes, operands and status of the datapath
interface p7_datapath_param_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int RW = $clog2(NREGS),
  parameter int SW = $clog2(WIDTH)
);
  logic [WIDTH-1:0] datapath_in, sximm8, mdata, PC, sximm5;
  logic [RW-1:0] writenum, readnum;
  logic write;
  logic [1:0] vsel;
  logic loada, loadb, loadc, loads, asel, bsel;
  logic [1:0] shift;
  logic [SW-1:0] shamt;
  logic shift_start;
  logic [2:0] ALUop;
  logic shift_busy, shift_done;
  logic [WIDTH-1:0] datapath_out;
  logic N_out, V_out, Z_out;
  modport master (
    output datapath_in, sximm8, mdata, PC, sximm5, writenum, readnum, write, vsel,
           loada, loadb, loadc, loads, asel, bsel, shift, shamt, shift_start, ALUop,
    input  shift_busy, shift_done, datapath_out, N_out, V_out, Z_out
  );
  modport slave (
    input  datapath_in, sximm8, mdata, PC, sximm5, writenum, readnum, write, vsel,
           loada, loadb, loadc, loads, asel, bsel, shift, shamt, shift_start, ALUop,
    output shift_busy, shift_done, datapath_out, N_out, V_out, Z_out
  );
endinterface

// File: rtl/p7_regfile_param.sv
// p7_regfile_param: register file; out-of-range indices ignore writes and read as 0
module p7_regfile_param #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             write,
  input  logic [RW-1:0]    writenum,
  input  logic [RW-1:0]    readnum,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] r [NREGS];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < NREGS; i++) r[i] <= '0;
    else
      for (int i = 0; i < NREGS; i++) if (write && writenum == RW'(i)) r[i] <= din;
  always_comb begin
    dout = '0;
    for (int i = 0; i < NREGS; i++) if (readnum == RW'(i)) dout = r[i];
  end
endmodule

// File: rtl/p7_datapath_param.sv
// p7_datapath_param: register file, A/B/C pipeline, iterative shifter and 8-op ALU
module p7_datapath_param
  import p7_defs::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int RW = $clog2(NREGS),
  parameter int SW = $clog2(WIDTH)
) (
  input logic clk,
  input logic reset_n,
  p7_datapath_param_if.slave bus
);
  logic [WIDTH-1:0] data_in, data_out, a, b, c, s, ain, bin, alu, s_next;
  logic [SW-1:0] cnt;
  logic [1:0] code;
  logic n, v, z, nf, vf, zf, done;
  sh_state_t st;
  always_comb begin
    data_in = bus.vsel == VSEL_IN ? bus.datapath_in :
              bus.vsel == VSEL_IMM8 ? bus.sximm8 :
              bus.vsel == VSEL_MDATA ? bus.mdata : bus.PC;
    ain = bus.asel ? '0 : a;
    bin = bus.bsel ? bus.sximm5 : s;
    s_next = code == SH_LSL ? s << 1 : code == SH_LSR ? s >> 1 : {s[WIDTH-1], s[WIDTH-1:1]};
  end
  p7_regfile_param #(.WIDTH(WIDTH), .NREGS(NREGS), .RW(RW)) u_rf (
    .clk(clk), .reset_n(reset_n), .write(bus.write), .writenum(bus.writenum),
    .readnum(bus.readnum), .din(data_in), .dout(data_out)
  );
  always_comb begin
    alu = '0;
    v = 1'b0;
    case (bus.ALUop)
      OP_ADD: begin
        alu = ain + bin;
        v = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_SUB: begin
        alu = ain - bin;
        v = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_AND: alu = ain & bin;
      OP_NOTB: alu = ~bin;
      OP_OR: alu = ain | bin;
      OP_XOR: alu = ain ^ bin;
      OP_PASSB: alu = bin;
      default: alu = ain;
    endcase
    n = alu[WIDTH-1];
    z = alu == '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a <= '0;
      b <= '0;
      c <= '0;
      {nf, vf, zf} <= '0;
    end else begin
      if (bus.loada) a <= data_out;
      if (bus.loadb) b <= data_out;
      if (bus.loadc) c <= alu;
      if (bus.loads) {nf, vf, zf} <= {n, v, z};
    end
  // shift code and amount are latched at start so the controller may move on
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st <= SH_IDLE;
      s <= '0;
      cnt <= '0;
      code <= SH_NONE;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (st == SH_RUN) begin
        s <= s_next;
        cnt <= cnt - 1'b1;
        if (cnt == SW'(1)) begin
          st <= SH_IDLE;
          done <= 1'b1;
        end
      end else if (bus.shift_start) begin
        s <= b;
        cnt <= bus.shamt;
        code <= bus.shift;
        if (bus.shamt == '0 || bus.shift == SH_NONE) done <= 1'b1;
        else st <= SH_RUN;
      end
    end
  assign bus.shift_busy = st == SH_RUN;
  assign bus.shift_done = done;
  assign bus.datapath_out = c;
  assign bus.N_out = nf;
  assign bus.V_out = vf;
  assign bus.Z_out = zf;
endmodule

// File: tb/tb_p7_datapath_param.sv
// tb_p7_datapath_param: directed plus random stimulus against a behavioural datapath model
module tb_p7_datapath_param;
  localparam int W = 16;
  localparam int NR = 5;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic chk_en = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  p7_datapath_param_if #(.WIDTH(W), .NREGS(NR)) bus();
  p7_datapath_param #(.WIDTH(W), .NREGS(NR)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] shiftn(input logic [W-1:0] x, input logic [1:0] code, input int k);
    case (code)
      2'd1: return x << k;
      2'd2: return x >> k;
      2'd3: return W'($signed(x) >>> k);
      default: return x;
    endcase
  endfunction

  logic [W-1:0] mR [NR];
  logic [W-1:0] mA, mB, mC, sh_b0;
  logic [1:0] sh_code;
  int sh_k, sh_amt;
  logic sh_act, mdone, mN, mV, mZ;
  logic [W-1:0] m_rd, m_wd, m_ain, m_bin, m_res;
  logic m_v;
  int sa, sb, sr;

  always_comb begin
    m_rd = (int'(bus.readnum) < NR) ? mR[int'(bus.readnum) % NR] : '0;
    m_wd = bus.vsel == 2'd0 ? bus.datapath_in : bus.vsel == 2'd1 ? bus.sximm8 :
           bus.vsel == 2'd2 ? bus.mdata : bus.PC;
    m_ain = bus.asel ? '0 : mA;
    m_bin = bus.bsel ? bus.sximm5 : shiftn(sh_b0, sh_code, sh_k);
    sa = int'($signed(m_ain));
    sb = int'($signed(m_bin));
    sr = bus.ALUop == 3'd0 ? sa + sb : sa - sb;
    m_v = 1'b0;
    case (bus.ALUop)
      3'd0, 3'd1: begin
        m_res = W'(sr);
        m_v = sr > 32767 || sr < -32768;
      end
      3'd2: m_res = m_ain & m_bin;
      3'd3: m_res = ~m_bin;
      3'd4: m_res = m_ain | m_bin;
      3'd5: m_res = m_ain ^ m_bin;
      3'd6: m_res = m_bin;
      default: m_res = m_ain;
    endcase
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NR; i++) mR[i] <= '0;
      mA <= '0; mB <= '0; mC <= '0; sh_b0 <= '0; sh_code <= '0;
      sh_k <= 0; sh_amt <= 0; sh_act <= 1'b0; mdone <= 1'b0;
      mN <= 1'b0; mV <= 1'b0; mZ <= 1'b0;
    end else begin
      if (bus.write && int'(bus.writenum) < NR) mR[int'(bus.writenum) % NR] <= m_wd;
      if (bus.loada) mA <= m_rd;
      if (bus.loadb) mB <= m_rd;
      if (bus.loadc) mC <= m_res;
      if (bus.loads) begin
        mN <= m_res[W-1];
        mV <= m_v;
        mZ <= m_res == 0;
      end
      mdone <= 1'b0;
      if (sh_act) begin
        sh_k <= sh_k + 1;
        if (sh_k + 1 == sh_amt) begin
          sh_act <= 1'b0;
          mdone <= 1'b1;
        end
      end else if (bus.shift_start) begin
        sh_b0 <= mB;
        sh_code <= bus.shift;
        sh_amt <= int'(bus.shamt);
        sh_k <= 0;
        if (bus.shamt == 0 || bus.shift == 2'd0) mdone <= 1'b1;
        else sh_act <= 1'b1;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    check("datapath_out", bus.datapath_out, mC);
    check("N_out", bus.N_out, mN);
    check("V_out", bus.V_out, mV);
    check("Z_out", bus.Z_out, mZ);
    check("shift_busy", bus.shift_busy, sh_act);
    check("shift_done", bus.shift_done, mdone);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.write = 0; bus.loada = 0; bus.loadb = 0; bus.loadc = 0; bus.loads = 0;
    bus.asel = 0; bus.bsel = 0; bus.shift_start = 0; bus.vsel = 0;
  endtask

  task automatic wr(input int idx, input logic [W-1:0] val);
    bus.writenum = 3'(idx); bus.datapath_in = val; bus.vsel = 0; bus.write = 1;
    tick(); idle();
  endtask

  task automatic lda(input int idx);
    bus.readnum = 3'(idx); bus.loada = 1; tick(); idle();
  endtask

  task automatic ldb(input int idx);
    bus.readnum = 3'(idx); bus.loadb = 1; tick(); idle();
  endtask

  task automatic alu(input logic [2:0] op);
    bus.ALUop = op; bus.loadc = 1; bus.loads = 1; tick(); idle();
  endtask

  task automatic shs(input logic [1:0] code, input logic [3:0] amt, output int n, output int nb);
    bus.shift = code; bus.shamt = amt; bus.shift_start = 1; tick(); idle();
    n = 0; nb = 0;
    while (!bus.shift_done && n < 40) begin
      if (bus.shift_busy) nb++;
      tick(); n++;
    end
  endtask

  initial begin
    int n, nb, dn, at;
    idle();
    bus.datapath_in = 0; bus.sximm8 = 0; bus.mdata = 0; bus.PC = 0; bus.sximm5 = 0;
    bus.writenum = 0; bus.readnum = 0; bus.shift = 0; bus.shamt = 0; bus.ALUop = 0;
    repeat (2) tick();
    reset_n = 1; chk_en = 1;
    tick();
    check("rst_dout", bus.datapath_out, 0);
    check("rst_flags", {bus.N_out, bus.V_out, bus.Z_out}, 0);
    check("rst_busy_done", {bus.shift_busy, bus.shift_done}, 0);

    wr(1, 16'h7FFF); wr(2, 16'h0001); lda(1); ldb(2);
    shs(2'd0, 4'd5, n, nb);
    check("none_latency", n, 0);
    alu(3'd0);
    check("add_dout", bus.datapath_out, 16'h8000);
    check("add_nvz", {bus.N_out, bus.V_out, bus.Z_out}, 3'b110);

    wr(3, 16'h8001); ldb(3);
    shs(2'd3, 4'd3, n, nb);
    check("asr_done_cycle", n, 3);
    check("asr_busy_cycles", nb, 3);
    alu(3'd6);
    check("asr_result", bus.datapath_out, 16'hF000);
    shs(2'd2, 4'd3, n, nb);
    alu(3'd6);
    check("lsr_result", bus.datapath_out, 16'h1000);

    wr(4, 16'h00F0); wr(0, 16'h1234); ldb(4);
    bus.shift = 2'd1; bus.shamt = 4'd5; bus.shift_start = 1; tick(); idle();
    dn = 0; at = 0;
    for (int i = 1; i <= 12; i++) begin
      if (bus.shift_done) begin dn++; at = i; end
      if (i == 1) begin
        bus.shift_start = 1; bus.shift = 2'd0; bus.shamt = 4'd1; bus.readnum = 0; bus.loadb = 1;
      end
      tick(); idle();
    end
    check("busy_restart_pulses", dn, 1);
    check("busy_restart_cycle", at, 6);
    alu(3'd6);
    check("lsl_orig_b", bus.datapath_out, 16'h1E00);
    shs(2'd0, 4'd0, n, nb);
    alu(3'd6);
    check("b_updated", bus.datapath_out, 16'h1234);

    for (int i = 0; i < NR; i++) wr(i, 16'h0100 + 16'(i));
    wr(6, 16'hABCD);
    lda(6); alu(3'd7);
    check("oob_read", bus.datapath_out, 0);
    check("oob_z", bus.Z_out, 1);
    for (int i = 0; i < NR; i++) begin
      lda(i); alu(3'd7);
      check("reg_intact", bus.datapath_out, 16'h0100 + 16'(i));
    end
    bus.writenum = 3; bus.datapath_in = 16'h3333; bus.write = 1; bus.readnum = 3; bus.loada = 1;
    tick(); idle();
    alu(3'd7);
    check("rw_same_edge_old", bus.datapath_out, 16'h0103);
    lda(3); alu(3'd7);
    check("rw_new_value", bus.datapath_out, 16'h3333);

    ldb(1);
    bus.shift = 2'd2; bus.shamt = 4'd7; bus.shift_start = 1; tick(); idle();
    tick(); tick();
    #1 reset_n = 0;
    #1;
    check("abort_busy", bus.shift_busy, 0);
    check("abort_dout", bus.datapath_out, 0);
    check("abort_flags", {bus.N_out, bus.V_out, bus.Z_out}, 0);
    tick();
    reset_n = 1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.shift_done) dn++;
      tick();
    end
    check("abort_no_done", dn, 0);
    for (int i = 0; i < NR; i++) begin
      lda(i); alu(3'd7);
      check("reg_cleared", bus.datapath_out, 0);
    end

    for (int i = 0; i < 3000; i++) begin
      reset_n = $urandom_range(0, 299) != 0;
      bus.datapath_in = 16'($urandom); bus.sximm8 = 16'($urandom);
      bus.mdata = 16'($urandom); bus.PC = 16'($urandom); bus.sximm5 = 16'($urandom);
      bus.writenum = 3'($urandom); bus.readnum = 3'($urandom); bus.vsel = 2'($urandom);
      bus.write = 1'($urandom); bus.loada = 1'($urandom); bus.loadb = 1'($urandom);
      bus.loadc = 1'($urandom); bus.loads = 1'($urandom);
      bus.asel = $urandom_range(0, 3) == 0; bus.bsel = $urandom_range(0, 3) == 0;
      bus.shift = 2'($urandom); bus.shamt = 4'($urandom);
      bus.shift_start = $urandom_range(0, 3) == 0; bus.ALUop = 3'($urandom);
      tick();
    end
    reset_n = 1; idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
